// File: rtl/stage_seq_pkg.sv
// Shared types and default constants for the instruction-stage sequencer.
package stage_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   localparam int unsigned DEF_NUM_STAGES   = 4;
   localparam int unsigned DEF_PHASE_CYCLES = 2;

endpackage

// File: rtl/stage_sequencer.sv
// Splits hw_clk into NUM_STAGES stages of PHASE_CYCLES cycles each, with
// run/halt, single-step, stall and a retired-instruction counter.
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
   parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                  i_hw_clk,
   input  logic                  i_hw_reset_n,
   input  logic                  i_run_en,
   input  logic                  i_step_req,
   input  logic                  i_stall,
   output logic [0:NUM_STAGES-1] o_is_stage,
   output logic [0:NUM_STAGES-1] o_stage_clk,
   output logic                  o_instr_done,
   output logic                  o_busy,
   output logic [CNT_W-1:0]      o_instr_count
);

   localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int SW = $clog2(NUM_STAGES);
   localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);
   localparam logic [SW-1:0] ST_LAST = SW'(NUM_STAGES - 1);
   localparam logic [0:NUM_STAGES-1] ONEHOT0 = {1'b1, {(NUM_STAGES-1){1'b0}}};

   state_t                  r_state;
   logic [SW-1:0]           r_stage;
   logic [PW-1:0]           r_phase;
   logic [0:NUM_STAGES-1]   r_is_stage;
   logic [0:NUM_STAGES-1]   r_stage_clk;
   logic                    r_instr_done;
   logic [CNT_W-1:0]        r_cnt;

   state_t                  w_state_nxt;
   logic [SW-1:0]           w_stage_nxt;
   logic [PW-1:0]           w_phase_nxt;
   logic                    w_adv;
   logic                    w_wrap;
   logic [0:NUM_STAGES-1]   w_is_stage_nxt;
   logic [0:NUM_STAGES-1]   w_stage_clk_nxt;

   // Next state, stage/phase advance and strobe decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_stage_nxt     = r_stage;
      w_phase_nxt     = r_phase;
      w_adv           = 1'b0;
      w_wrap          = 1'b0;
      w_is_stage_nxt  = '0;
      w_stage_clk_nxt = '0;
      case (r_state)
         IDLE: begin
            // Parked at stage0/phase0; stall has no meaning here.
            w_stage_nxt = '0;
            w_phase_nxt = '0;
            if (i_run_en)        w_state_nxt = RUN;
            else if (i_step_req) w_state_nxt = STEP;
         end
         RUN, STEP: begin
            if (!i_stall) begin
               if (r_phase == PH_LAST) begin
                  w_phase_nxt = '0;
                  w_adv       = 1'b1;
                  if (r_stage == ST_LAST) begin
                     // Instruction boundary: the only place halt/step-end act.
                     w_stage_nxt = '0;
                     w_wrap      = 1'b1;
                     if (r_state == STEP || !i_run_en) w_state_nxt = IDLE;
                  end else begin
                     w_stage_nxt = r_stage + 1'b1;
                  end
               end else begin
                  w_phase_nxt = r_phase + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_stage_nxt = '0;
            w_phase_nxt = '0;
         end
      endcase
      w_is_stage_nxt[w_stage_nxt] = 1'b1;
      if (w_adv) w_stage_clk_nxt[r_stage] = 1'b1;
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_hw_clk or negedge i_hw_reset_n) begin
      if (!i_hw_reset_n) begin
         r_state      <= IDLE;
         r_stage      <= '0;
         r_phase      <= '0;
         r_is_stage   <= ONEHOT0;
         r_stage_clk  <= '0;
         r_instr_done <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_stage      <= w_stage_nxt;
         r_phase      <= w_phase_nxt;
         r_is_stage   <= w_is_stage_nxt;
         r_stage_clk  <= w_stage_clk_nxt;
         r_instr_done <= w_wrap;
         if (w_wrap) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_is_stage    = r_is_stage;
   assign o_stage_clk   = r_stage_clk;
   assign o_instr_done  = r_instr_done;
   assign o_busy        = (r_state != IDLE);
   assign o_instr_count = r_cnt;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default 4x2 instance plus a 6x1,
// 2-bit-counter instance.
module tb_stage_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        run_a, step_a, stall_a;
   logic [0:3]  is_a, sclk_a;
   logic        done_a, busy_a;
   logic [15:0] cnt_a;

   logic        run_b, step_b, stall_b;
   logic [0:5]  is_b, sclk_b;
   logic        done_b, busy_b;
   logic [1:0]  cnt_b;

   int          n_chk = 0;
   int          n_pass = 0;
   int          e;
   logic [0:3]  exp4;
   logic [0:5]  exp6;

   stage_sequencer #(.NUM_STAGES(4), .PHASE_CYCLES(2), .CNT_W(16)) u_dut_a (
      .i_hw_clk(clk), .i_hw_reset_n(rst_n), .i_run_en(run_a), .i_step_req(step_a),
      .i_stall(stall_a), .o_is_stage(is_a), .o_stage_clk(sclk_a),
      .o_instr_done(done_a), .o_busy(busy_a), .o_instr_count(cnt_a)
   );

   stage_sequencer #(.NUM_STAGES(6), .PHASE_CYCLES(1), .CNT_W(2)) u_dut_b (
      .i_hw_clk(clk), .i_hw_reset_n(rst_n), .i_run_en(run_b), .i_step_req(step_b),
      .i_stall(stall_b), .o_is_stage(is_b), .o_stage_clk(sclk_b),
      .o_instr_done(done_b), .o_busy(busy_b), .o_instr_count(cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [0:3] oh4(input int i);
      oh4 = '0;
      oh4[i] = 1'b1;
   endfunction

   function automatic logic [0:5] oh6(input int i);
      oh6 = '0;
      oh6[i] = 1'b1;
   endfunction

   initial begin
      rst_n = 1'b0;
      run_a = 0; step_a = 0; stall_a = 0;
      run_b = 0; step_b = 0; stall_b = 0;
      #12;
      chk("rst_is_a", is_a, oh4(0));
      chk("rst_is_b", is_b, oh6(0));
      chk("rst_cnt_a", cnt_a, 0);
      rst_n = 1'b1;

      // Idle with no stimulus.
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle_is", is_a, oh4(0));
         chk("idle_sclk", sclk_a, 0);
         chk("idle_busy", busy_a, 0);
         chk("idle_cnt", cnt_a, 0);
      end

      // Free run: three instructions back to back.
      run_a = 1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         e = c - 1;
         exp4 = '0;
         if (e > 0 && e % 2 == 0) exp4 = oh4(((e / 2) - 1) % 4);
         chk("run_stage", is_a, oh4((e / 2) % 4));
         chk("run_sclk", sclk_a, exp4);
         chk("run_done", done_a, (e > 0 && e % 8 == 0));
         chk("run_cnt", cnt_a, e / 8);
         chk("run_busy", busy_a, 1);
      end

      // Stall three cycles inside stage2: instruction stretches to 11 cycles.
      for (int c = 1; c <= 11; c++) begin
         if (c == 5) stall_a = 1;
         if (c == 8) stall_a = 0;
         tick();
         chk("stall_done", done_a, c == 11);
         if (c >= 5 && c <= 7) begin
            chk("stall_stage", is_a, oh4(2));
            chk("stall_sclk", sclk_a, 0);
         end
         if (c == 9) chk("stall_sclk2", sclk_a, oh4(2));
      end
      chk("stall_cnt", cnt_a, 4);
      chk("stall_nogap", is_a, oh4(0));
      chk("stall_busy", busy_a, 1);

      // Halt requested during stage1: finishes the instruction, then idles.
      for (int c = 1; c <= 8; c++) begin
         if (c == 3) run_a = 0;
         tick();
         exp4 = '0;
         if (c % 2 == 0) exp4 = oh4(c / 2 - 1);
         chk("halt_sclk", sclk_a, exp4);
         chk("halt_busy", busy_a, c < 8);
         chk("halt_done", done_a, c == 8);
      end
      chk("halt_cnt", cnt_a, 5);
      chk("halt_is", is_a, oh4(0));
      tick();
      tick();
      chk("halt_idle", busy_a, 0);
      chk("halt_cnt2", cnt_a, 5);

      // Single step, with a second request mid-step that must be ignored.
      step_a = 1;
      tick();
      step_a = 0;
      chk("step_busy0", busy_a, 1);
      for (int c = 1; c <= 8; c++) begin
         if (c == 3) step_a = 1;
         if (c == 4) step_a = 0;
         tick();
         chk("step_busy", busy_a, c < 8);
         chk("step_done", done_a, c == 8);
      end
      chk("step_cnt", cnt_a, 6);
      chk("step_is", is_a, oh4(0));
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("step_idle", busy_a, 0);
      end

      // Asynchronous reset in the middle of stage2.
      run_a = 1;
      tick();
      for (int c = 0; c < 5; c++) tick();
      chk("pre_rst_stage", is_a, oh4(2));
      rst_n = 1'b0;
      #2;
      chk("arst_is", is_a, oh4(0));
      chk("arst_sclk", sclk_a, 0);
      chk("arst_done", done_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_cnt", cnt_a, 0);
      run_a = 0;
      rst_n = 1'b1;
      tick();
      chk("arst_after", busy_a, 0);

      // Six stages, one cycle each, 2-bit counter wrap.
      chk("b_idle_is", is_b, oh6(0));
      run_b = 1;
      for (int c = 1; c <= 31; c++) begin
         tick();
         e = c - 1;
         exp6 = '0;
         if (e > 0) exp6 = oh6((e - 1) % 6);
         chk("b_stage", is_b, oh6(e % 6));
         chk("b_sclk", sclk_b, exp6);
         chk("b_done", done_b, (e > 0 && e % 6 == 0));
         chk("b_cnt", cnt_b, (e / 6) % 4);
      end
      run_b = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
